peak_window_hold: RTL and testbench
===================================

Name: peak_window_hold

Overview:
- Downstream consumer of the 12-bit max compare stage in the TOOLBOX chain.
- Takes a strobed stream of 12-bit unsigned samples and tracks the running maximum over a fixed window of WINDOW samples.
- At the end of each window it emits the peak value as a one-cycle result strobe and holds it until the next window result.
- Feeds display/threshold logic that needs one peak per block of samples rather than a per-sample max.

Parameters:
- DATA_W, 12, sample and peak width (unsigned).
- WINDOW, 256, samples per window; legal range 2..65536.
- CNT_W, $clog2(WINDOW), width of the sample counter and the peak index.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- CLR  in  1  synchronous window restart; discards the partial window.
- IN_VALID  in  1  sample strobe; IN_DATA is sampled when high.
- IN_DATA  in  DATA_W  unsigned sample.
- OUT_VALID  out  1  one-cycle pulse when a window completes.
- OUT_PEAK  out  DATA_W  peak of the last completed window; held between pulses.
- OUT_COUNT  out  CNT_W  samples accepted in the current window (0..WINDOW-1).
- BUSY  out  1  high while a partial window holds at least one sample.

Behaviour:
- Reset (RST high, async):
  - OUT_VALID=0, OUT_PEAK=0, OUT_COUNT=0, BUSY=0.
  - Running max=0; FSM=IDLE.
  - Reset mid-window discards the partial window; no OUT_VALID is produced for it.
- FSM states: IDLE and ACCUM.
  - IDLE: no samples in the current window. On IN_VALID: running max<=IN_DATA, count<=1, go ACCUM.
  - ACCUM: on IN_VALID, running max<=IN_DATA if IN_DATA > max (strict compare); count increments.
  - Window end: the sample that brings the count to WINDOW is included in the compare. On the next edge, OUT_PEAK<=final max (including that sample), OUT_VALID=1 for exactly one cycle, count<=0, go IDLE.
- Latency: OUT_VALID asserts on the clock edge after the final sample's IN_VALID edge, i.e. one cycle registered.
- Back-to-back windows:
  - A sample arriving in the cycle OUT_VALID is high is the first sample of the next window. No bubble and no lost sample.
  - Sustained IN_VALID=1 gives one OUT_VALID every WINDOW cycles.
- Gaps: IN_VALID low cycles are ignored; the window counts samples, not cycles.
- CLR:
  - Forces IDLE with count=0 and running max=0.
  - OUT_PEAK keeps its last value; no OUT_VALID is produced.
  - CLR has priority over a simultaneous IN_VALID, which is dropped.
- Counter: counts 0..WINDOW-1 and wraps to 0 at window end; it never reaches WINDOW. OUT_COUNT is the registered counter value.
- BUSY = (state==ACCUM).
- Arithmetic: unsigned compare only; no sign extension. A max of 4095 remains 4095 for the rest of the window.

Optional Feature:
- Macro: PEAK_INDEX_EN.
- Defined:
  - Adds port OUT_INDEX  out  CNT_W: zero-based position within the window of the sample that produced OUT_PEAK.
  - On ties, the first occurrence wins (consistent with the strict compare).
  - OUT_INDEX updates together with OUT_PEAK and resets to 0.
- Undefined: the port and the index register are absent; all other behaviour is identical.

Decomposition:
- Shared package toolbox_pkg:
  - SAMPLE_W=12.
  - FSM state typedef {IDLE, ACCUM}.
  - Default WINDOW constant.
- Sub-module peak_compare: combinational candidate/current compare.
  - Outputs the update-enable (strict >) and the selected value.
  - Reused by the index logic.
- Top level holds the FSM, counter and output registers.

Test Plan:
- WINDOW=4, continuous IN_VALID, data 5,9,3,7 -> one OUT_VALID pulse one cycle after sample 4; OUT_PEAK=9; OUT_INDEX=1 when PEAK_INDEX_EN.
- WINDOW=4, data 2,8,8,1 with gaps of 0-3 idle cycles between samples -> OUT_PEAK=8, OUT_INDEX=1 (first tie), exactly one pulse.
- WINDOW=4, back-to-back data 1,2,3,4,10,0,0,0 -> pulses with OUT_PEAK=4 then 10; the sample during the first pulse is counted in window 2.
- Full scale, WINDOW=4, data 4095,0,4095,0 -> OUT_PEAK=4095, OUT_INDEX=0; between pulses OUT_PEAK holds and OUT_VALID stays 0.
- CLR asserted with IN_VALID after 2 samples -> OUT_COUNT=0, BUSY=0, no pulse, OUT_PEAK unchanged; a following full window of 6,6,6,6 -> OUT_PEAK=6.
- RST asserted asynchronously mid-window (between edges) -> all outputs 0 immediately. After release, a 4-sample window of 1,1,1,1 gives OUT_PEAK=1.

Source files
------------

// File: rtl/toolbox_pkg.sv
// Shared definitions for the TOOLBOX sample-processing chain.
// Provides the default sample width, the peak-window FSM state type and
// the default window length used by peak_window_hold.
package toolbox_pkg;

    // Width of one unsigned sample in the chain
    localparam int SAMPLE_W = 12;

    // Default number of samples per peak window
    localparam int DEFAULT_WINDOW = 256;

    // Peak-window FSM: IDLE holds no samples, ACCUM holds a partial window
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage : toolbox_pkg

// File: rtl/peak_compare.sv
// Combinational candidate/current compare for the running-peak tracker.
// o_upd is a strict unsigned greater-than, so on ties the current value
// (the earlier sample) is kept. o_sel is the value the running maximum
// takes after this sample. The update flag also steers the index logic.
module peak_compare #(
    parameter int W = 12
) (
    input  logic [W-1:0] i_cand,
    input  logic [W-1:0] i_cur,
    output logic         o_upd,
    output logic [W-1:0] o_sel
);

    // Strict compare and select of the new running maximum
    always_comb begin
        o_upd = (i_cand > i_cur);
        o_sel = o_upd ? i_cand : i_cur;
    end

endmodule : peak_compare

// File: rtl/peak_window_hold.sv
// Windowed peak detector: tracks the running maximum of a strobed stream
// of unsigned samples over WINDOW accepted samples, then emits the peak as
// a one-cycle OUT_VALID strobe and holds OUT_PEAK until the next result.
// The window-closing sample is folded into the result on the same edge it
// is accepted, so the next sample (even in the OUT_VALID cycle) starts a
// new window with no bubble.
// Optional build macro PEAK_INDEX_EN adds OUT_INDEX, the zero-based
// position of the peak sample within its window (first occurrence on ties).
module peak_window_hold
    import toolbox_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int WINDOW = DEFAULT_WINDOW,
    parameter int CNT_W  = $clog2(WINDOW)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    output logic [DATA_W-1:0] OUT_PEAK,
    output logic [CNT_W-1:0]  OUT_COUNT,
`ifdef PEAK_INDEX_EN
    output logic [CNT_W-1:0]  OUT_INDEX,
`endif
    output logic              BUSY
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_max;
    logic [DATA_W-1:0]   r_peak;
    logic                r_valid;
`ifdef PEAK_INDEX_EN
    logic [CNT_W-1:0]    r_idx_run;
    logic [CNT_W-1:0]    r_index;
`endif

    logic                w_upd;
    logic [DATA_W-1:0]   w_sel;
    logic                w_last;

    peak_compare #(
        .W (DATA_W)
    ) u_cmp (
        .i_cand (IN_DATA),
        .i_cur  (r_max),
        .o_upd  (w_upd),
        .o_sel  (w_sel)
    );

    // Sample currently presented would bring the window to WINDOW samples
    always_comb begin
        w_last = (r_cnt == LAST_CNT);
    end

    // Window FSM, sample counter, running maximum and result registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_max     <= '0;
            r_peak    <= '0;
            r_valid   <= 1'b0;
`ifdef PEAK_INDEX_EN
            r_idx_run <= '0;
            r_index   <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (CLR) begin
                // Restart drops any simultaneous sample; the last result is kept
                r_state   <= IDLE;
                r_cnt     <= '0;
                r_max     <= '0;
`ifdef PEAK_INDEX_EN
                r_idx_run <= '0;
`endif
            end else if (IN_VALID) begin
                case (r_state)
                    IDLE: begin
                        r_max     <= IN_DATA;
                        r_cnt     <= CNT_W'(1);
`ifdef PEAK_INDEX_EN
                        r_idx_run <= '0;
`endif
                        r_state   <= ACCUM;
                    end
                    ACCUM: begin
                        if (w_last) begin
                            // Closing sample is compared and published on this edge
                            r_peak    <= w_sel;
`ifdef PEAK_INDEX_EN
                            r_index   <= w_upd ? r_cnt : r_idx_run;
                            r_idx_run <= '0;
`endif
                            r_valid   <= 1'b1;
                            r_cnt     <= '0;
                            r_max     <= '0;
                            r_state   <= IDLE;
                        end else begin
                            r_max <= w_sel;
`ifdef PEAK_INDEX_EN
                            if (w_upd) begin
                                r_idx_run <= r_cnt;
                            end
`endif
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_max   <= '0;
                    end
                endcase
            end
        end
    end

    // Output mapping from the registered state
    always_comb begin
        OUT_VALID = r_valid;
        OUT_PEAK  = r_peak;
        OUT_COUNT = r_cnt;
        BUSY      = (r_state == ACCUM);
`ifdef PEAK_INDEX_EN
        OUT_INDEX = r_index;
`endif
    end

endmodule : peak_window_hold

// File: tb/tb_peak_window_hold.sv
// Directed bench for peak_window_hold with WINDOW=4. Stimulus pushes the
// hand-computed window result into a queue when it issues a window's last
// sample; an independent monitor pops and compares on every OUT_VALID.
module tb_peak_window_hold;

    localparam int DATA_W = 12;
    localparam int WINDOW = 4;
    localparam int CNT_W  = 2;

    logic              CLK;
    logic              RST;
    logic              CLR;
    logic              IN_VALID;
    logic [DATA_W-1:0] IN_DATA;
    logic              OUT_VALID;
    logic [DATA_W-1:0] OUT_PEAK;
    logic [CNT_W-1:0]  OUT_COUNT;
    logic              BUSY;
`ifdef PEAK_INDEX_EN
    logic [CNT_W-1:0]  OUT_INDEX;
`endif

    typedef struct {
        int peak;
        int idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   n_pulse = 0;

    peak_window_hold #(
        .DATA_W (DATA_W),
        .WINDOW (WINDOW),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CLR       (CLR),
        .IN_VALID  (IN_VALID),
        .IN_DATA   (IN_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_PEAK  (OUT_PEAK),
        .OUT_COUNT (OUT_COUNT),
`ifdef PEAK_INDEX_EN
        .OUT_INDEX (OUT_INDEX),
`endif
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample(input int d, input int gap);
        IN_VALID = 1'b1;
        IN_DATA  = d[DATA_W-1:0];
        tick();
        IN_VALID = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic push(input int peak, input int idx);
        exp_t e;
        e.peak = peak;
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    // Monitor: every result strobe must match the oldest expected window
    always @(negedge CLK) begin
        if (!RST && OUT_VALID) begin
            n_pulse++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got OUT_VALID=1 peak=%0d expected no pulse (t=%0t)",
                         OUT_PEAK, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("peak", int'(OUT_PEAK), e.peak);
`ifdef PEAK_INDEX_EN
                chk("index", int'(OUT_INDEX), e.idx);
`endif
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST      = 1'b0;
        CLR      = 1'b0;
        IN_VALID = 1'b0;
        IN_DATA  = '0;
        #1 RST = 1'b1;
        #2;
        chk("rst_valid", int'(OUT_VALID), 0);
        chk("rst_peak",  int'(OUT_PEAK),  0);
        chk("rst_count", int'(OUT_COUNT), 0);
        chk("rst_busy",  int'(BUSY),      0);
        repeat (2) @(posedge CLK);
        #3 RST = 1'b0;
        tick();
        tick();

        // Continuous window 5,9,3,7 -> 9 at index 1
        sample(5, 0);
        sample(9, 0);
        chk("t1_count2", int'(OUT_COUNT), 2);
        chk("t1_busy",   int'(BUSY),      1);
        sample(3, 0);
        push(9, 1);
        sample(7, 0);
        chk("t1_count_wrap", int'(OUT_COUNT), 0);
        chk("t1_busy_end",   int'(BUSY),      0);
        repeat (3) tick();

        // Gapped window with a tie: 2,8,8,1 -> 8 at index 1
        sample(2, 1);
        sample(8, 3);
        sample(8, 0);
        push(8, 1);
        sample(1, 2);
        repeat (2) tick();

        // Back-to-back windows; sample 10 lands in the OUT_VALID cycle
        sample(1, 0);
        sample(2, 0);
        sample(3, 0);
        push(4, 3);
        sample(4, 0);
        chk("t3_pulse_cycle_valid", int'(OUT_VALID), 1);
        sample(10, 0);
        chk("t3_next_window_count", int'(OUT_COUNT), 1);
        sample(0, 0);
        sample(0, 0);
        push(10, 0);
        sample(0, 0);
        repeat (2) tick();

        // Full scale 4095,0,4095,0 -> 4095 at index 0, then held
        sample(4095, 0);
        sample(0, 0);
        sample(4095, 0);
        push(4095, 0);
        sample(0, 0);
        repeat (4) tick();
        chk("t4_hold_peak",  int'(OUT_PEAK),  4095);
        chk("t4_hold_valid", int'(OUT_VALID), 0);

        // CLR after 2 samples, with a colliding sample that must be dropped
        sample(20, 0);
        sample(30, 0);
        CLR      = 1'b1;
        IN_VALID = 1'b1;
        IN_DATA  = 12'd50;
        tick();
        CLR      = 1'b0;
        IN_VALID = 1'b0;
        chk("t5_clr_count", int'(OUT_COUNT), 0);
        chk("t5_clr_busy",  int'(BUSY),      0);
        chk("t5_clr_peak",  int'(OUT_PEAK),  4095);
        repeat (2) tick();
        sample(6, 0);
        sample(6, 0);
        sample(6, 0);
        push(6, 0);
        sample(6, 0);
        repeat (2) tick();

        // Asynchronous reset between edges mid-window
        sample(100, 0);
        sample(200, 0);
        #2 RST = 1'b1;
        #1;
        chk("t6_rst_valid", int'(OUT_VALID), 0);
        chk("t6_rst_peak",  int'(OUT_PEAK),  0);
        chk("t6_rst_count", int'(OUT_COUNT), 0);
        chk("t6_rst_busy",  int'(BUSY),      0);
        @(posedge CLK);
        #3 RST = 1'b0;
        tick();
        sample(1, 0);
        sample(1, 0);
        sample(1, 0);
        push(1, 0);
        sample(1, 0);
        repeat (4) tick();

        chk("pending_results", exp_q.size(), 0);
        chk("pulse_total",     n_pulse,      7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_peak_window_hold
